// File: rtl/led_breathe.sv
// LED drive stage: glitch-free N-bit PWM with steady, blink-gated and
// triangle "breathing" brightness, fed by the blink divider square wave.
module led_breathe #(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 65536,
  parameter int BRIGHT   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             blink_in,
  output logic             LED,
  output logic [PWM_W-1:0] level,
  output logic             period_start
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEADY  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [PWM_W-1:0] MAX        = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] BRIGHT_V   = PWM_W'(BRIGHT);
  localparam logic [23:0]      PRESC_LAST = 24'(STEP_DIV - 1);

  mode_t            modeSel;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic [23:0]      presc_q, presc_d;
  dir_t             dir_q, dir_d;
  logic             led_q, led_d;
  logic             ps_q, ps_d;

  assign modeSel = mode_t'(mode);

  always_comb begin
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    level_d = level_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    led_d   = 1'b0;
    ps_d    = 1'b0;
    if (en) begin
      cnt_d = cnt_q + PWM_W'(1);
      ps_d  = (cnt_q == MAX);
      led_d = (modeSel != MODE_OFF) && (cnt_q < duty_q);
      // Duty only reloads at the period boundary, using the pre-step level.
      if (cnt_q == MAX) begin
        case (modeSel)
          MODE_OFF:     duty_d = '0;
          MODE_STEADY:  duty_d = BRIGHT_V;
          MODE_BLINK:   duty_d = blink_in ? BRIGHT_V : '0;
          MODE_BREATHE: duty_d = level_q;
          default:      duty_d = '0;
        endcase
      end
      if (modeSel == MODE_BREATHE) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          // Turning points move straight to the neighbour so each extreme lasts one step.
          if (dir_q == DIR_UP) begin
            if (level_q == MAX) begin
              dir_d   = DIR_DOWN;
              level_d = MAX - PWM_W'(1);
            end else begin
              level_d = level_q + PWM_W'(1);
            end
          end else begin
            if (level_q == '0) begin
              dir_d   = DIR_UP;
              level_d = PWM_W'(1);
            end else begin
              level_d = level_q - PWM_W'(1);
            end
          end
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      level_q <= '0;
      presc_q <= '0;
      dir_q   <= DIR_UP;
      led_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      level_q <= level_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      ps_q    <= ps_d;
    end
  end

  assign LED          = led_q;
  assign level        = level_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_led_breathe.sv
// Scoreboard bench for led_breathe: three instances share stimulus and differ
// only in BRIGHT (128, 255, 0), all with a fast 4-cycle breathe step.
module tb_led_breathe;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       blink_in;
  logic       ledMain, ledHi, ledZero;
  logic [7:0] levelMain, levelHi, levelZero;
  logic       psMain, psHi, psZero;

  int checks;
  int errors;
  int expQ[$];

  led_breathe #(.PWM_W(8), .STEP_DIV(4), .BRIGHT(128)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .blink_in(blink_in),
    .LED(ledMain), .level(levelMain), .period_start(psMain)
  );

  led_breathe #(.PWM_W(8), .STEP_DIV(4), .BRIGHT(255)) dutHi (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .blink_in(blink_in),
    .LED(ledHi), .level(levelHi), .period_start(psHi)
  );

  led_breathe #(.PWM_W(8), .STEP_DIV(4), .BRIGHT(0)) dutZero (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .blink_in(blink_in),
    .LED(ledZero), .level(levelZero), .period_start(psZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal triangle: level after edge n, counting edges from reset release.
  function automatic int triLevel(input int n);
    int k;
    k = n / 4;
    if (k <= 255) return k;
    else if (k <= 510) return 510 - k;
    else return k - 510;
  endfunction

  task automatic test_reset();
    int exp;
    int n;
    bit seen;
    rst = 1'b1; en = 1'b1; mode = 2'd3; blink_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(0);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (ledMain !== 1'(exp) || levelMain !== 8'(exp) || psMain !== 1'(exp)) begin
        errors++;
        $display("[TB] FAIL reset_state: LED=%0d level=%0d ps=%0d, wanted all %0d", ledMain, levelMain, psMain, exp);
      end
    end
    rst = 1'b0;
    expQ.push_back(256);
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (psMain === 1'b1) seen = 1'b1;
    end
    exp = expQ.pop_front();
    checks++;
    if (!seen || n != exp) begin
      errors++;
      $display("[TB] FAIL first_period_start: at edge %0d (seen=%0d), wanted %0d", n, seen, exp);
    end
    checks++;
    if (psHi !== 1'b1 || psZero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_period_start_all: hi=%0d zero=%0d, wanted 1", psHi, psZero);
    end
  endtask

  task automatic test_breathe();
    int exp;
    int peak;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd3; en = 1'b1;
    peak = 0;
    for (int n = 1; n <= 2044; n++) begin
      expQ.push_back(triLevel(n));
      tick();
      exp = expQ.pop_front();
      if (levelMain === 8'd255) peak++;
      checks++;
      if (levelMain !== 8'(exp)) begin
        errors++;
        $display("[TB] FAIL breathe_level edge %0d: got %0d wanted %0d", n, levelMain, exp);
      end
    end
    expQ.push_back(4);
    exp = expQ.pop_front();
    checks++;
    if (peak != exp) begin
      errors++;
      $display("[TB] FAIL breathe_peak_hold: %0d cycles at 255, wanted %0d", peak, exp);
    end
    expQ.push_back(1);
    exp = expQ.pop_front();
    checks++;
    if (levelHi !== 8'(exp) || levelZero !== 8'(exp)) begin
      errors++;
      $display("[TB] FAIL breathe_wrap_all: hi=%0d zero=%0d wanted %0d", levelHi, levelZero, exp);
    end
  endtask

  task automatic test_override();
    int exp;
    int expLed;
    int highs;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd3; en = 1'b1;
    repeat (300) tick();
    // Duty was latched at edge 256 from the pre-step level 63.
    expQ.push_back(75); expQ.push_back(1);
    exp = expQ.pop_front(); expLed = expQ.pop_front();
    checks++;
    if (levelMain !== 8'(exp) || ledMain !== 1'(expLed)) begin
      errors++;
      $display("[TB] FAIL override_setup: level=%0d LED=%0d wanted %0d/%0d", levelMain, ledMain, exp, expLed);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expQ.push_back(75);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (ledMain !== 1'b0 || psMain !== 1'b0 || levelMain !== 8'(exp)) begin
        errors++;
        $display("[TB] FAIL en_low_freeze: LED=%0d ps=%0d level=%0d wanted 0/0/%0d", ledMain, psMain, levelMain, exp);
      end
    end
    en = 1'b1;
    for (int r = 1; r <= 212; r++) begin
      expQ.push_back((r == 212) ? 1 : 0);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (psMain !== 1'(exp)) begin
        errors++;
        $display("[TB] FAIL resume_period_start r=%0d: got %0d wanted %0d", r, psMain, exp);
      end
      if (r == 3 || r == 4) begin
        exp = (r == 3) ? 75 : 76;
        checks++;
        if (levelMain !== 8'(exp)) begin
          errors++;
          $display("[TB] FAIL resume_level r=%0d: got %0d wanted %0d", r, levelMain, exp);
        end
      end
      if (r == 19 || r == 20) begin
        exp = (r == 19) ? 1 : 0;
        checks++;
        if (ledMain !== 1'(exp)) begin
          errors++;
          $display("[TB] FAIL resume_duty_edge r=%0d: LED=%0d wanted %0d", r, ledMain, exp);
        end
      end
    end
    tick();
    checks++;
    if (ledMain !== 1'b1) begin
      errors++;
      $display("[TB] FAIL led_before_off: LED=%0d wanted 1", ledMain);
    end
    mode = 2'd0;
    highs = 0;
    expQ.push_back(0); expQ.push_back(128);
    repeat (300) begin
      tick();
      if (ledMain === 1'b1) highs++;
    end
    exp = expQ.pop_front();
    checks++;
    if (highs != exp) begin
      errors++;
      $display("[TB] FAIL mode_off_led: %0d highs wanted %0d", highs, exp);
    end
    exp = expQ.pop_front();
    checks++;
    if (levelMain !== 8'(exp)) begin
      errors++;
      $display("[TB] FAIL mode_off_level_hold: got %0d wanted %0d", levelMain, exp);
    end
    mode = 2'd3;
    tick(); tick();
    checks++;
    if (levelMain !== 8'd128) begin
      errors++;
      $display("[TB] FAIL reenter_hold: level=%0d wanted 128", levelMain);
    end
    tick();
    checks++;
    if (levelMain !== 8'd129) begin
      errors++;
      $display("[TB] FAIL reenter_step: level=%0d wanted 129", levelMain);
    end
  endtask

  task automatic test_steady();
    int exp;
    int n;
    int highs;
    bit seen;
    bit first;
    mode = 2'd1;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      tick(); n++;
      if (psMain === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL steady_latch_timeout: no period_start within %0d cycles", n);
    end
    expQ.push_back(1); expQ.push_back(128); expQ.push_back(1);
    highs = 0;
    first = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) first = ledMain;
      if (ledMain === 1'b1) highs++;
    end
    exp = expQ.pop_front();
    checks++;
    if (first !== 1'(exp)) begin
      errors++;
      $display("[TB] FAIL steady_rise_after_ps: LED=%0d wanted %0d", first, exp);
    end
    exp = expQ.pop_front();
    checks++;
    if (highs != exp) begin
      errors++;
      $display("[TB] FAIL steady_highs: %0d wanted %0d", highs, exp);
    end
    exp = expQ.pop_front();
    checks++;
    if (psMain !== 1'(exp)) begin
      errors++;
      $display("[TB] FAIL steady_period: ps=%0d wanted %0d", psMain, exp);
    end
  endtask

  task automatic test_blink();
    int exp;
    int n;
    int highs;
    bit seen;
    mode = 2'd2; blink_in = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      tick(); n++;
      if (psMain === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL blink_latch_timeout: no period_start within %0d cycles", n);
    end
    // blink_in drops at the start of the third counted period; it lands one latch later.
    for (int w = 0; w < 5; w++) begin
      blink_in = (w < 2);
      expQ.push_back((w < 3) ? 128 : 0);
      highs = 0;
      repeat (256) begin
        tick();
        if (ledMain === 1'b1) highs++;
      end
      exp = expQ.pop_front();
      checks++;
      if (highs != exp) begin
        errors++;
        $display("[TB] FAIL blink_window %0d: %0d highs wanted %0d", w, highs, exp);
      end
    end
  endtask

  task automatic test_extremes();
    int n;
    int hMain, hHi, hZero;
    bit seen;
    mode = 2'd1;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      tick(); n++;
      if (psMain === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL extremes_latch_timeout: no period_start within %0d cycles", n);
    end
    expQ.push_back(128); expQ.push_back(255); expQ.push_back(0);
    hMain = 0; hHi = 0; hZero = 0;
    repeat (256) begin
      tick();
      if (ledMain === 1'b1) hMain++;
      if (ledHi === 1'b1) hHi++;
      if (ledZero === 1'b1) hZero++;
    end
    n = expQ.pop_front();
    checks++;
    if (hMain != n) begin errors++; $display("[TB] FAIL extremes_mid: %0d highs wanted %0d", hMain, n); end
    n = expQ.pop_front();
    checks++;
    if (hHi != n) begin errors++; $display("[TB] FAIL extremes_max: %0d highs wanted %0d", hHi, n); end
    n = expQ.pop_front();
    checks++;
    if (hZero != n) begin errors++; $display("[TB] FAIL extremes_zero: %0d highs wanted %0d", hZero, n); end
    expQ.push_back(0);
    hZero = 0;
    repeat (1024) begin
      tick();
      if (ledZero === 1'b1) hZero++;
    end
    n = expQ.pop_front();
    checks++;
    if (hZero != n) begin
      errors++;
      $display("[TB] FAIL extremes_zero_long: %0d highs wanted %0d", hZero, n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b1; mode = 2'd3; blink_in = 1'b0;
    test_reset();
    test_breathe();
    test_override();
    test_steady();
    test_blink();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_breathe.md
Name: led_breathe

Overview:
- Downstream LED drive stage. Consumes the square wave from the free-running blink divider and drives the board LED pin.
- Adds brightness control through an N-bit PWM, plus a "breathing" mode in which duty ramps up and down along a triangle.
- A 2-bit mode input selects off, steady, blink or breathe.
- Sits between the blink divider output and the top-level LED port.

Parameters:
- PWM_W, 8, PWM/duty width. PWM period is 2^PWM_W clk cycles. MAX = 2^PWM_W-1.
- STEP_DIV, 65536, clk cycles per breathe step. Legal range 1..2^24.
- BRIGHT, 128, duty used in steady and blink modes. Must be ≤ MAX.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  stage enable. Low: all counters hold, LED forced 0.
- mode  input  2  0=off, 1=steady, 2=blink, 3=breathe
- blink_in  input  1  square wave from blink divider, same clk domain
- LED  output  1  PWM drive to pin, registered
- level  output  PWM_W  current breathe ramp value
- period_start  output  1  one-cycle pulse when pwm_cnt wraps to 0

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high. Clock port clk, reset port rst.
  - Values in the cycle after rst is sampled high: pwm_cnt=0, duty=0, presc=0, level=0, dir=up, LED=0, period_start=0.
  - rst mid-operation aborts the ramp and restarts from level 0, dir up.
- PWM counter:
  - pwm_cnt (PWM_W bits) increments by 1 each cycle when en=1.
  - Wraps MAX→0 modulo 2^PWM_W.
  - period_start is registered: it is 1 in the cycle after pwm_cnt==MAX was sampled with en=1, otherwise 0.
- Duty latch:
  - duty updates only when pwm_cnt==MAX and en=1, so there are no mid-period glitches.
  - Value loaded by mode:
    - mode 0: 0
    - mode 1: BRIGHT
    - mode 2: blink_in ? BRIGHT : 0, with blink_in sampled in that same cycle
    - mode 3: level
- LED output:
  - LED <= en && mode!=0 && (pwm_cnt < duty). Registered, so one cycle latency from the compare.
  - duty=0 gives LED constantly 0. duty=MAX gives high for MAX of every 2^PWM_W cycles.
  - mode==0 or en==0 forces LED=0 on the next clk edge, regardless of duty.
- Breathe ramp (active only when mode==3 and en==1):
  - presc counts 0..STEP_DIV-1, then wraps to 0. The step tick is asserted in the cycle presc==STEP_DIV-1.
  - On tick with dir=up: if level==MAX then dir<=down and level<=MAX-1; otherwise level<=level+1.
  - On tick with dir=down: if level==0 then dir<=up and level<=1; otherwise level<=level-1.
  - The peak (MAX) and the floor (0) are each held for exactly one step. Full triangle period = 2·MAX steps.
  - Outside mode 3, presc, level and dir hold their values. Re-entering mode 3 resumes from the held values.
- Mode changes:
  - Mode may change at any cycle; the change takes effect on LED at the next duty latch.
  - Exceptions: mode 0 and en=0 act on the next edge, as stated above.
- Simultaneous events:
  - rst has priority over everything.
  - Duty latch and ramp step in the same cycle: duty takes the pre-step level.

Test Plan:
- Reset: hold rst 3 cycles with en=1, mode=3 → LED=0, level=0, period_start=0. First period_start pulse appears 256 cycles after rst deasserts (PWM_W=8).
- Steady: mode=1, BRIGHT=128, en=1. After the first duty latch, count LED highs per 256-cycle window → exactly 128. The rising edge of LED falls in the cycle after period_start.
- Blink gating: mode=2, blink_in=1 for 3 periods then 0 → 128 highs in each of periods 2-3. The change lands at the next latch; afterwards 0 highs per period.
- Breathe ramp: STEP_DIV=4, mode=3 → level steps every 4 cycles 0,1,…,255, then 254,…,0, then 1. level==255 is held for exactly 4 cycles. Full cycle = 510 steps.
- Enable/off override: during mode=3 with LED=1, drop en → LED=0 next cycle, pwm_cnt and level frozen. Raise en → counting resumes from the frozen values. Repeat with mode=0 → same LED=0 response.
- Extremes: BRIGHT=255, mode=1 → 255 highs per 256 cycles. BRIGHT=0 → LED never high over 1024 cycles.
